// File: rtl/hash_match_merge_if.sv
// Hit-merge bus: two upstream hit lanes in, one valid/ready hit stream plus drop statistics out.
interface hash_match_merge_if #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] din0;
    logic              din0_valid;
    logic [DWIDTH-1:0] din1;
    logic              din1_valid;
    logic [DWIDTH-1:0] dout;
    logic              dout_lane;
    logic              dout_valid;
    logic              dout_ready;
    logic              stat_clear;
    logic              overflow;
    logic [15:0]       drop_cnt;

    modport master (
        output din0, din0_valid, din1, din1_valid, dout_ready, stat_clear,
        input  dout, dout_lane, dout_valid, overflow, drop_cnt
    );

    modport slave (
        input  din0, din0_valid, din1, din1_valid, dout_ready, stat_clear,
        output dout, dout_lane, dout_valid, overflow, drop_cnt
    );
endinterface

// File: rtl/hash_match_merge.sv
// Merges up to two hash hits per cycle into one {lane, id} FIFO stream; 1-cycle latency.
// Upstream has no backpressure: hits that do not fit are dropped and counted.
module hash_match_merge #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8,
    parameter bit DEDUP  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    hash_match_merge_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic              lane;
        logic [DWIDTH-1:0] id;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_occ;
    logic [15:0]     r_drop_cnt;
    logic            r_overflow;

    logic            w_dup;
    logic            w_c0;
    logic            w_c1;
    logic            w_acc0;
    logic            w_acc1;
    logic            w_pop;
    logic [AW:0]     w_free;
    logic [1:0]      w_push_n;
    logic [1:0]      w_drop_n;
    logic [AW-1:0]   w_wslot1;
    logic [15:0]     w_cnt_base;
    logic [16:0]     w_cnt_sum;

    always_comb begin
        w_dup    = DEDUP && bus.din0_valid && bus.din1_valid && (bus.din0 == bus.din1);
        w_c0     = bus.din0_valid;
        w_c1     = bus.din1_valid && !w_dup;
        // Free space ignores a same-cycle pop: the slot is not yet released.
        w_free   = (AW+1)'(DEPTH) - r_occ;
        w_acc0   = w_c0 && (w_free != '0);
        w_acc1   = w_c1 && (w_c0 ? (w_free >= (AW+1)'(2)) : (w_free != '0));
        w_push_n = {1'b0, w_acc0} + {1'b0, w_acc1};
        w_drop_n = ({1'b0, w_c0} + {1'b0, w_c1}) - w_push_n;
        w_pop    = (r_occ != '0) && bus.dout_ready;
        w_wslot1 = r_wptr + AW'(w_acc0);
        w_cnt_base = bus.stat_clear ? 16'h0000 : r_drop_cnt;
        w_cnt_sum  = {1'b0, w_cnt_base} + 17'(w_drop_n);
    end

    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_mem[r_wptr] <= {1'b0, bus.din0};
        end
        if (w_acc1) begin
            r_mem[w_wslot1] <= {1'b1, bus.din1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_drop_cnt <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            r_wptr     <= r_wptr + AW'(w_push_n);
            r_rptr     <= r_rptr + AW'(w_pop);
            r_occ      <= r_occ + (AW+1)'(w_push_n) - (AW+1)'(w_pop);
            r_drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
            r_overflow <= (r_overflow && !bus.stat_clear) || (w_drop_n != 2'd0);
        end
    end

    assign bus.dout       = r_mem[r_rptr].id;
    assign bus.dout_lane  = r_mem[r_rptr].lane;
    assign bus.dout_valid = (r_occ != '0);
    assign bus.overflow   = r_overflow;
    assign bus.drop_cnt   = r_drop_cnt;
endmodule
